// File: rtl/alu_pkg.sv
// Shared encodings for the execution unit: ALU op codes, one-hot branch
// selects, FSM states, and the combinational ALU / branch decoders.
package alu_pkg;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSll = 3'b100,
        AluSlt = 3'b101,
        AluSrl = 3'b110,
        AluXor = 3'b111
    } alu_op_e;

    typedef enum logic [3:0] {
        BrNone = 4'b0000,
        BrBeq  = 4'b0001,
        BrBlt  = 4'b0010,
        BrBne  = 4'b0100,
        BrBge  = 4'b1000
    } br_sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned DataW  = 32;
    localparam int unsigned ShamtW = 5;

    // Single-cycle ops. Shifts return A unchanged: that is the shamt == 0 result,
    // non-zero shift amounts go through the iterative shifter instead.
    function automatic logic [DataW-1:0] alu_compute(alu_op_e op, logic [DataW-1:0] a,
                                                     logic [DataW-1:0] b);
        logic [DataW-1:0] res;
        res = a;
        case (op)
            AluAdd: res = a + b;
            AluSub: res = a - b;
            AluAnd: res = a & b;
            AluOr:  res = a | b;
            AluSlt: res = {{(DataW-1){1'b0}}, ($signed(a) < $signed(b))};
            AluXor: res = a ^ b;
            AluSll: res = a;
            AluSrl: res = a;
            default: res = a;
        endcase
        return res;
    endfunction

    // Branch decision; anything other than exactly one select bit gives not-taken.
    function automatic logic branch_eval(logic [3:0] br, logic [DataW-1:0] a,
                                         logic [DataW-1:0] b);
        logic taken;
        taken = 1'b0;
        case (br)
            BrBeq:   taken = (a == b);
            BrBlt:   taken = ($signed(a) < $signed(b));
            BrBne:   taken = (a != b);
            BrBge:   taken = ($signed(a) >= $signed(b));
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Single-bit-per-cycle shifter: load operand and count, then shift once per step
// until the count reaches zero.
module alu_shift_iter
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              right_i,
    input  logic [DataW-1:0]  data_i,
    input  logic [ShamtW-1:0] shamt_i,
    input  logic              step_i,
    output logic [DataW-1:0]  next_data_o,
    output logic              last_o
);

    logic [DataW-1:0]  data_q, data_d;
    logic [ShamtW-1:0] count_q, count_d;
    logic              right_q, right_d;

    // Value after one more step; srl zero-fills from the top.
    assign next_data_o = right_q ? {1'b0, data_q[DataW-1:1]} : {data_q[DataW-2:0], 1'b0};

    // This step is the final one when exactly one shift remains.
    assign last_o = (count_q == ShamtW'(1));

    // Next-state: load takes priority, otherwise step while shifts remain.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        right_d = right_q;
        if (load_i) begin
            data_d  = data_i;
            count_d = shamt_i;
            right_d = right_i;
        end else if (step_i && (count_q != '0)) begin
            data_d  = next_data_o;
            count_d = count_q - ShamtW'(1);
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            count_q <= '0;
            right_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            right_q <= right_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ALU ops and branch compare, iterative
// shifts, registered result/flags held until the next completion.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [3:0]       Branch,
    input  logic [DataW-1:0] SrcA,
    input  logic [DataW-1:0] SrcB,
    output logic             done,
    output logic [DataW-1:0] ALUResult,
    output logic             Zero,
    output logic             BranchTaken
);

    state_e           state_q, state_d;
    logic [DataW-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             br_q, br_d;
    logic             br_pend_q, br_pend_d;

    alu_op_e          op;
    logic             accept;
    logic             is_shift;
    logic             shift_load;
    logic             shift_step;
    logic             shift_last;
    logic [DataW-1:0] shift_next;

    assign op         = alu_op_e'(ALUControl);
    assign accept     = in_valid && (state_q == StIdle);
    assign is_shift   = (op == AluSll) || (op == AluSrl);
    assign shift_load = accept && is_shift && (SrcB[ShamtW-1:0] != '0);
    assign shift_step = (state_q == StShift);

    alu_shift_iter u_shift (
        .clk_i       (clk),
        .rst_i       (reset),
        .load_i      (shift_load),
        .right_i     (op == AluSrl),
        .data_i      (SrcA),
        .shamt_i     (SrcB[ShamtW-1:0]),
        .step_i      (shift_step),
        .next_data_o (shift_next),
        .last_o      (shift_last)
    );

    // Next-state and result capture; results only change at a completion edge.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        br_d      = br_q;
        br_pend_d = br_pend_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (shift_load) begin
                        // Branch is resolved on the accepted operands and parked
                        // so the visible flag only moves at completion.
                        state_d   = StShift;
                        br_pend_d = branch_eval(Branch, SrcA, SrcB);
                    end else begin
                        state_d  = StDone;
                        result_d = alu_compute(op, SrcA, SrcB);
                        zero_d   = (result_d == '0);
                        br_d     = branch_eval(Branch, SrcA, SrcB);
                    end
                end
            end
            StShift: begin
                if (shift_last) begin
                    state_d  = StDone;
                    result_d = shift_next;
                    zero_d   = (shift_next == '0);
                    br_d     = br_pend_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b1;
            br_q      <= 1'b0;
            br_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            br_q      <= br_d;
            br_pend_q <= br_pend_d;
        end
    end

    // Handshake and registered outputs.
    always_comb begin
        in_ready    = (state_q == StIdle);
        done        = (state_q == StDone);
        ALUResult   = result_q;
        Zero        = zero_q;
        BranchTaken = br_q;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operation request present.
REQ-004 SHALL have port in_ready, output, 1 bit: unit accepts a request this cycle.
REQ-005 SHALL have port ALUControl, input, 3 bits: op code. 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 110 srl, 111 xor.
REQ-006 SHALL have port Branch, input, 4 bits: one-hot branch select. 0001 beq, 0010 blt, 0100 bne, 1000 bge, 0000 none.
REQ-007 SHALL have ports SrcA and SrcB, input, 32 bits each: operands.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-009 SHALL have port ALUResult, output, 32 bits: registered result.
REQ-010 SHALL have port Zero, output, 1 bit: registered flag, ALUResult == 0.
REQ-011 SHALL have port BranchTaken, output, 1 bit: registered branch decision.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid & in_ready.
REQ-014 On accepting a non-shift op, the unit SHALL latch operands and go to DONE. Results SHALL be registered at that edge, and done SHALL assert in the next cycle (latency 1).
REQ-015 add and sub SHALL wrap modulo 2^32, with no carry or overflow output.
REQ-016 slt SHALL produce 32'd1 if $signed(SrcA) < $signed(SrcB), and 32'd0 otherwise.
REQ-017 sll and srl SHALL use shamt = SrcB[4:0] and shift the latched SrcA by one bit per cycle in SHIFT. srl is logical and zero-fills.
REQ-018 For a shift with shamt = 0, the unit SHALL go directly to DONE with result = SrcA (latency 1).
REQ-019 For a shift with shamt = N > 0, the unit SHALL stay in SHIFT for N cycles, then enter DONE (latency N+1). The counter SHALL decrement from N to 0.
REQ-020 DONE SHALL last exactly one cycle with done = 1, then return to IDLE. in_ready SHALL be 0 during DONE.
REQ-021 BranchTaken SHALL evaluate against the full 32-bit comparison of the latched SrcA and SrcB:
- beq: A == B
- bne: A != B
- blt: signed A < B
- bge: signed A >= B
REQ-022 BranchTaken SHALL be 0 when Branch is 0000 or not one-hot. When a Branch bit is set, ALUResult SHALL still follow ALUControl.
REQ-023 ALUResult, Zero and BranchTaken SHALL hold their values from completion until the next completion.
REQ-024 in_valid asserted while the unit is busy SHALL be ignored; the unit SHALL NOT queue requests.
REQ-025 Input changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-026 Asserting reset at any time, including mid-SHIFT, SHALL force:
- state IDLE
- in_ready = 1 after release
- done = 0
- ALUResult = 0
- Zero = 1
- BranchTaken = 0
- shift counter = 0
REQ-027 An operation interrupted by reset SHALL be discarded, with no done pulse.

Structure
REQ-028 The ALUControl encodings, the Branch one-hot encodings and the state enum SHALL reside in a shared package, alu_pkg, also used by the ALU decoder.
REQ-029 The single-bit iterative shifter (load, step, count, last) SHALL be a sub-module named alu_shift_iter. All other logic SHALL be inline.

Verification
REQ-030 The bench SHALL drive add, A=32'hFFFF_FFFF, B=1 → done one cycle after accept; ALUResult=0, Zero=1, BranchTaken=0.
REQ-031 The bench SHALL drive sub with Branch=0010, A=-5, B=3 → ALUResult=32'hFFFF_FFF8, BranchTaken=1. The same operands with Branch=1000 → BranchTaken=0.
REQ-032 The bench SHALL drive sll, A=1, B=32'd31 → in_ready=0 for 32 cycles; done on cycle 32 after accept; ALUResult=32'h8000_0000.
REQ-033 The bench SHALL drive srl with shamt=0 and A=32'h8000_0001 → latency 1, result unchanged. A second in_valid during DONE SHALL be ignored.
REQ-034 The bench SHALL assert reset on cycle 3 of an sll with shamt=10 → no done pulse; outputs return to reset values; the next add completes normally.
REQ-035 The bench SHALL drive slt, A=32'h7FFF_FFFF, B=32'h8000_0000 → ALUResult=0. Swapping the operands → ALUResult=1.
